// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: entry layout, counter widths
// and wrap-detection states.
package commit_trace_pkg;

    localparam int SEQ_W      = 16;
    localparam int OVF_W      = 16;
    localparam int RD_W       = 5;
    localparam int PC_W_DEF   = 9;
    localparam int DATA_W_DEF = 32;

    // Default-width trace entry; the top re-declares the same layout with its
    // own PC_W/DATA_W so non-default builds keep the field order.
    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic                  we;
        logic [RD_W-1:0]       rd;
        logic [DATA_W_DEF-1:0] data;
        logic [SEQ_W-1:0]      seq;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage. Full/empty come from the occupancy counter, so the
// pointers are free to wrap modulo DEPTH. The head is shown as zero while
// empty so the drain fields never expose stale or uninitialised storage.
module trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  entry_t        din,
    output entry_t        dout,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy update; push+pop together keeps count, even when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired instructions into a FIFO for a
// drain consumer, tagging each with a commit sequence number and counting
// commits dropped while full.
// Optional wrap detection (macro COMMIT_TRACE_WRAP_DETECT_EN) freezes capture
// once the PC returns to 0 after running, so the trace ends at the wrap.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 9,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [PC_W-1:0]          commit_pc,
    input  logic                     commit_we,
    input  logic [4:0]               commit_rd,
    input  logic [DATA_W-1:0]        commit_data,
    input  logic                     drain_ready,
    output logic                     drain_valid,
    output logic [PC_W-1:0]          drain_pc,
    output logic                     drain_we,
    output logic [4:0]               drain_rd,
    output logic [DATA_W-1:0]        drain_data,
    output logic [15:0]              drain_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt,
    output logic                     frozen
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    logic [SEQ_W-1:0] seq;
    logic             full;
    logic             pop;
    logic             blocked;
    logic             live;
    logic             accept;
    logic             drop;
    entry_t           din;
    entry_t           head;

    assign pop    = drain_valid & drain_ready;
    // A live commit is one eligible for capture; it lands if there is room
    // or the head leaves in the same cycle.
    assign live   = commit_valid & ~frozen & ~blocked;
    assign accept = live & (~full | pop);
    assign drop   = live & full & ~pop;

    assign din.pc   = commit_pc;
    assign din.we   = commit_we;
    assign din.rd   = commit_we ? commit_rd : '0;
    assign din.data = commit_we ? commit_data : '0;
    assign din.seq  = seq;

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .valid (drain_valid),
        .full  (full),
        .count (count)
    );

    assign drain_pc   = head.pc;
    assign drain_we   = head.we;
    assign drain_rd   = head.rd;
    assign drain_data = head.data;
    assign drain_seq  = head.seq;

    // Sequence number advances on every unfrozen commit, dropped ones included.
    always_ff @(posedge clk) begin
        if (rst)                      seq <= '0;
        else if (commit_valid & ~frozen) seq <= seq + 1'b1;
    end

    // Saturating count of commits lost to a full buffer.
    always_ff @(posedge clk) begin
        if (rst)                           overflow_cnt <= '0;
        else if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
    end

`ifdef COMMIT_TRACE_WRAP_DETECT_EN
    trace_state_t state;

    // Once running, a commit at PC 0 marks the wrap and is itself not captured.
    assign blocked = (state == RUN) && (commit_pc == '0);

    // Wrap-detect FSM; only reset leaves FROZEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            frozen <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept && commit_pc != '0) state <= RUN;
                RUN: if (commit_valid && commit_pc == '0) begin
                    state  <= FROZEN;
                    frozen <= 1'b1;
                end
                default: state <= FROZEN;
            endcase
        end
    end
`else
    assign blocked = 1'b0;
    assign frozen  = 1'b0;
`endif

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16; trace entries held, power of 2, minimum 2.
REQ-002 Parameter PC_W, default 9; committed PC width, matching the fetch PC.
REQ-003 Parameter DATA_W, default 32; architectural register data width.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port commit_valid  input  1  one instruction retired this cycle.
REQ-007 Port commit_pc  input  PC_W  PC of the retiring instruction.
REQ-008 Port commit_we  input  1  retiring instruction writes an architectural register.
REQ-009 Port commit_rd  input  5  architectural destination register index.
REQ-010 Port commit_data  input  DATA_W  value written to commit_rd.
REQ-011 Port drain_ready  input  1  consumer accepts the head entry.
REQ-012 Port drain_valid  output  1  head entry present.
REQ-013 Port drain_pc / drain_we / drain_rd / drain_data  output  PC_W/1/5/DATA_W  head entry fields.
REQ-014 Port drain_seq  output  16  commit sequence number of the head entry.
REQ-015 Port count  output  $clog2(DEPTH)+1  entries currently held.
REQ-016 Port overflow_cnt  output  16  commits dropped because the buffer was full.
REQ-017 Port frozen  output  1  capture stopped by wrap detection.

Function
REQ-018 A commit is accepted when commit_valid=1, frozen=0, and (count<DEPTH or a pop occurs in the same cycle).
REQ-019 An accepted commit writes {pc, we, rd, data, seq}; when commit_we=0, rd and data are stored as 0.
REQ-020 Pop occurs when drain_valid=1 and drain_ready=1.
REQ-021 Capture latency is 1 cycle: an entry accepted into an empty buffer gives drain_valid=1 on the following cycle.
REQ-022 drain_* fields are held stable while drain_valid=1 and drain_ready=0.
REQ-023 Simultaneous push and pop leave count unchanged; this also applies when count=DEPTH.
REQ-024 Push to a full buffer with no pop is dropped; overflow_cnt increments and saturates at 0xFFFF.
REQ-025 The sequence counter increments by 1 on every commit_valid while not frozen, dropped commits included; it wraps 0xFFFF->0 and the first commit after reset has seq 0.
REQ-026 Read and write pointers wrap modulo DEPTH; full/empty are derived from count, never from pointer equality alone.
REQ-027 Pop from an empty buffer is impossible because drain_valid=0; drain_ready is ignored while empty.

Reset
REQ-028 On rst=1 at a clock edge: count=0, pointers=0, drain_valid=0, drain_* fields=0, seq=0, overflow_cnt=0, frozen=0, FSM=IDLE.
REQ-029 Reset mid-operation discards all held entries with no further drain handshake.
REQ-030 Commits presented during the reset cycle are not captured.

Configuration
REQ-031 Macro COMMIT_TRACE_WRAP_DETECT_EN enables wrap detection with FSM states IDLE, RUN and FROZEN.
REQ-032 FSM transitions: IDLE->RUN on an accepted commit with pc!=0; RUN->FROZEN on commit_valid with pc==0.
REQ-033 The commit that causes RUN->FROZEN is not captured.
REQ-034 FROZEN is left only by reset; while frozen=1, commits are ignored (seq and overflow_cnt unchanged) and draining continues.
REQ-035 Without the macro: no FSM, frozen is tied 0, and every commit is subject only to REQ-018..REQ-027.

Structure
REQ-036 Package commit_trace_pkg holds trace_entry_t (packed pc, we, rd, data, seq), SEQ_W=16, OVF_W=16, and enum trace_state_t {IDLE, RUN, FROZEN}.
REQ-037 Storage and pointer logic sit in one sub-module, trace_fifo, parameterised on DEPTH and trace_entry_t; the top holds seq, overflow and FSM logic.

Verification
REQ-038 Reset, then one commit pc=0x004, we=1, rd=5, data=0xDEADBEEF with drain_ready=1 -> next cycle drain_valid=1 with those fields and seq=0; the cycle after, count=0.
REQ-039 20 back-to-back commits, drain_ready=0, DEPTH=16 -> count=16, overflow_cnt=4; draining yields seq 0..15 in order.
REQ-040 Buffer full, then commit_valid=1 and drain_ready=1 in the same cycle -> count stays 16, overflow_cnt unchanged, new entry appears last.
REQ-041 drain_ready=0 held for 5 cycles with an entry present -> drain_* constant throughout.
REQ-042 Macro defined: commits pc=0x000, 0x004, 0x1FC, then 0x000 -> first pc=0 captured (state IDLE), frozen=1 after the fourth commit, 3 entries drained, later commits ignored.
REQ-043 Reset asserted with count=7 -> next cycle count=0, drain_valid=0, overflow_cnt=0, and the next commit has seq=0.
